// File: rtl/fifo_ctrl.sv
// Pointer/flag controller that runs a registered-read dual-port RAM as a circular FIFO.
// Optional FIFO_CTRL_ERR_EN: overflow/underflow latch a sticky error and park the FSM in ERROR.
module fifo_ctrl #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [ADDR_BITS:0]   umbral_af,
  input  logic [ADDR_BITS:0]   umbral_ae,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 pop,
  input  logic [DATA_BITS-1:0] ram_data_out,
  output logic                 ram_write,
  output logic [ADDR_BITS-1:0] ram_addr_write,
  output logic [DATA_BITS-1:0] ram_data_in,
  output logic                 ram_read,
  output logic [ADDR_BITS-1:0] ram_addr_read,
  output logic [DATA_BITS-1:0] pop_data,
  output logic                 pop_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 error,
  output logic [2:0]           state
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [ADDR_BITS:0] DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic [ADDR_BITS:0]   af_q, af_d;
  logic [ADDR_BITS:0]   ae_q, ae_d;
  logic                 pop_valid_q;

  logic run, full_w, empty_w, push_acc, pop_acc;

  // Requests are only honoured out of reset in the two operating states.
  assign run     = reset && ((state_q == S_IDLE) || (state_q == S_ACTIVE));
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  assign pop_acc  = run && pop && !empty_w;
  assign push_acc = run && push && (!full_w || pop_acc);

`ifdef FIFO_CTRL_ERR_EN
  logic overflow, underflow, error_q;
  assign overflow  = run && push && full_w && !pop_acc;
  assign underflow = run && pop && empty_w;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    af_d     = af_q;
    ae_d     = ae_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_acc && !pop_acc)      count_d = count_q + 1'b1;
    else if (pop_acc && !push_acc) count_d = count_q - 1'b1;

    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        af_d = umbral_af;
        ae_d = umbral_ae;
        if (!init) state_d = S_IDLE;
      end
      S_IDLE: begin
        // A push wins over a threshold reload request in the same cycle.
        if (push_acc)  state_d = S_ACTIVE;
        else if (init) state_d = S_INIT;
      end
      S_ACTIVE: if (count_d == '0) state_d = S_IDLE;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_RESET;
    endcase

`ifdef FIFO_CTRL_ERR_EN
    if (overflow || underflow) state_d = S_ERROR;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_RESET;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      af_q        <= '0;
      ae_q        <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      af_q        <= af_d;
      ae_q        <= ae_d;
      pop_valid_q <= pop_acc;
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge clk) begin
    if (!reset)                     error_q <= 1'b0;
    else if (overflow || underflow) error_q <= 1'b1;
  end
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign ram_write      = push_acc;
  assign ram_addr_write = wr_ptr_q;
  assign ram_data_in    = push_acc ? push_data : '0;
  assign ram_read       = pop_acc;
  assign ram_addr_read  = rd_ptr_q;

  assign pop_data  = ram_data_out;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign state     = state_q;

  assign fifo_full    = full_w;
  assign fifo_empty   = empty_w;
  // A zero almost-full threshold (e.g. while thresholds are cleared) keeps the flag low.
  assign almost_full  = (af_q != '0) && (count_q >= af_q);
  assign almost_empty = (count_q <= ae_q);

endmodule
